// File: rtl/spi_pkg.sv
// spi_pkg: types and constants shared by the SPI slave files.
package spi_pkg;

   localparam int SPI_SYNC_STAGES = 2;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CS} spi_state_t;

   // Leading edge of the mode; swap rise/fall arguments to get the trailing edge.
   function automatic logic lead_edge(spi_mode_t m, logic rise, logic fall);
      return m.cpol ? fall : rise;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-flop synchronizer for one asynchronous input bit.
module spi_sync
   import spi_pkg::*;
#(
   parameter int   N       = SPI_SYNC_STAGES,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] ff_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) ff_q <= {N{RST_VAL}};
      else         ff_q <= {ff_q[N-2:0], d_i};
   end

   assign q_o = ff_q[N-1];

endmodule

// File: rtl/spi_slave_axis.sv
// spi_slave_axis: SPI slave moving bytes between the SPI pins and AXI-Stream TX/RX.
// Define SPI_SLAVE_AXIS_STATUS_EN to add overflow, underrun and frame_count outputs.
module spi_slave_axis
   import spi_pkg::*;
#(
   parameter int         CLOCK_POLARITY_G = 0,
   parameter int         CLOCK_PHASE_G    = 0,
   parameter int         MSB_FIRST_G      = 1,
   parameter logic [7:0] UNDERRUN_BYTE_G  = 8'hFF
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       busy
`ifdef SPI_SLAVE_AXIS_STATUS_EN
   ,
   output logic        overflow,
   output logic        underrun,
   output logic [15:0] frame_count
`endif
);

   localparam spi_mode_t  MODE      = '{cpol: CLOCK_POLARITY_G != 0, cpha: CLOCK_PHASE_G != 0};
   localparam logic       MSB       = MSB_FIRST_G != 0;
   localparam logic [1:0] INIT_DONE = 2'(SPI_SYNC_STAGES + 1);

   spi_state_t state_q, state_d;
   logic       sclk_s, mosi_s, cs_s, sclk_prev_q, cs_prev_q;
   logic [1:0] init_q;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d, rx_next, tx_q, tx_d, hold_q, hold_d, m_data_q, m_data_d;
   logic       hold_v_q, hold_v_d, m_valid_q, m_valid_d, m_last_q, m_last_d, tready_q, tready_d;
   logic       active, go, cs_rise, cs_fall, sclk_rise, sclk_fall, lead, trail;
   logic       sample, shift, byte_done, fwd, stall, push, unused_tlast;

   spi_sync #(.RST_VAL(MODE.cpol)) u_sync_sclk (.clk_in(clk_in), .rst_in(rst_in), .d_i(sclk), .q_o(sclk_s));
   spi_sync #(.RST_VAL(1'b0))      u_sync_mosi (.clk_in(clk_in), .rst_in(rst_in), .d_i(mosi), .q_o(mosi_s));
   spi_sync #(.RST_VAL(1'b1))      u_sync_cs   (.clk_in(clk_in), .rst_in(rst_in), .d_i(cs),   .q_o(cs_s));

   assign unused_tlast = s_axis_tlast;
   assign sclk_rise    = sclk_s & ~sclk_prev_q;
   assign sclk_fall    = ~sclk_s & sclk_prev_q;
   assign cs_rise      = cs_s & ~cs_prev_q;
   assign cs_fall      = ~cs_s & cs_prev_q;
   assign lead         = lead_edge(MODE, sclk_rise, sclk_fall);
   assign trail        = lead_edge(MODE, sclk_fall, sclk_rise);
   assign active       = state_q == ACTIVE;

   // Until the cs synchronizer has settled after reset, its edges are not trusted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (init_q == INIT_DONE) state_d = cs_fall ? ACTIVE : (cs_s ? IDLE : WAIT_CS);
         ACTIVE:  if (cs_rise) state_d = IDLE;
         default: if (cs_s) state_d = IDLE;
      endcase
   end

   // Both phases shift only after the first sample of a byte, so cnt_q != 0 covers either mode.
   always_comb begin
      go        = (state_q == IDLE) && (state_d == ACTIVE);
      sample    = active && !cs_rise && (MODE.cpha ? trail : lead);
      shift     = active && !cs_rise && (cnt_q != 3'd0) && (MODE.cpha ? lead : trail);
      rx_next   = MSB ? {rx_q[6:0], mosi_s} : {mosi_s, rx_q[7:1]};
      byte_done = sample && (cnt_q == 3'd7);
      fwd       = hold_v_q && (byte_done || (active && cs_rise));
      stall     = m_valid_q && !m_axis_tready;
      push      = fwd && !stall;
      cnt_d     = (!active || cs_rise) ? 3'd0 : cnt_q + {2'b0, sample};
      rx_d      = sample ? rx_next : rx_q;
      tready_d  = go || byte_done;
      tx_d      = tready_q ? (s_axis_tvalid ? s_axis_tdata : UNDERRUN_BYTE_G)
                : shift ? (MSB ? {tx_q[6:0], 1'b0} : {1'b0, tx_q[7:1]}) : tx_q;
      hold_d    = byte_done ? rx_next : hold_q;
      hold_v_d  = byte_done || (hold_v_q && !(active && cs_rise));
      m_valid_d = push || stall;
      m_data_d  = push ? hold_q : m_data_q;
      m_last_d  = push ? cs_rise : m_last_q;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         init_q      <= 2'd0;
         sclk_prev_q <= MODE.cpol;
         cs_prev_q   <= 1'b1;
         cnt_q       <= 3'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         tready_q    <= 1'b0;
         hold_q      <= 8'h00;
         hold_v_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= 8'h00;
         m_last_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_q + {1'b0, init_q != INIT_DONE};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         tready_q    <= tready_d;
         hold_q      <= hold_d;
         hold_v_q    <= hold_v_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_last_q    <= m_last_d;
      end
   end

   assign miso_oe       = ~cs_s;
   assign busy          = ~cs_s;
   assign miso          = miso_oe & (MSB ? tx_q[7] : tx_q[0]);
   assign s_axis_tready = tready_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;

`ifdef SPI_SLAVE_AXIS_STATUS_EN
   logic        overflow_q, underrun_q;
   logic [15:0] frame_count_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         overflow_q    <= 1'b0;
         underrun_q    <= 1'b0;
         frame_count_q <= 16'h0000;
      end else begin
         overflow_q    <= overflow_q | (fwd & stall);
         underrun_q    <= underrun_q | (tready_q & ~s_axis_tvalid);
         frame_count_q <= frame_count_q + {15'b0, active && cs_rise && (frame_count_q != 16'hFFFF)};
      end
   end

   assign overflow    = overflow_q;
   assign underrun    = underrun_q;
   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_spi_slave_axis.sv
// tb_spi_slave_axis: directed checks of spi_slave_axis over all SPI modes and bit orders.
module tb_spi_slave_axis;

   localparam int N = 5;
   localparam int H = 8;
   localparam logic [N-1:0] CPOL_V = 5'b01100;
   localparam logic [N-1:0] CPHA_V = 5'b01010;
   localparam logic [N-1:0] MSB_V  = 5'b01111;

   typedef struct {
      int         d;
      logic       tv;
      logic [7:0] stx;
      logic [7:0] mtx;
      logic [7:0] mrx;
      logic [7:0] data;
   } vec_t;

   logic clk_in = 1'b0, rst_in = 1'b0, mosi = 1'b0, mon_en = 1'b0;
   logic [N-1:0] sclk = CPOL_V, cs = '1, s_valid = '0, m_ready = '0;
   logic [N-1:0] miso, miso_oe, busy, s_ready, m_valid, m_last;
   logic [7:0]   s_data [N] = '{default: 8'h00};
   logic [7:0]   m_data [N];
`ifdef SPI_SLAVE_AXIS_STATUS_EN
   logic [N-1:0] ovf, udr;
   logic [15:0]  fc [N];
`endif
   int errors = 0, checks = 0;
   logic [8:0] got [$];
   vec_t tbl [7];
   logic [7:0] r0, r1, r2;

   always #5 clk_in = ~clk_in;

   for (genvar g = 0; g < N; g++) begin : g_dut
      spi_slave_axis #(
         .CLOCK_POLARITY_G(int'(CPOL_V[g])),
         .CLOCK_PHASE_G(int'(CPHA_V[g])),
         .MSB_FIRST_G(int'(MSB_V[g]))
      ) u_dut (
         .clk_in(clk_in), .rst_in(rst_in), .sclk(sclk[g]), .mosi(mosi), .cs(cs[g]),
         .miso(miso[g]), .miso_oe(miso_oe[g]),
         .s_axis_tdata(s_data[g]), .s_axis_tvalid(s_valid[g]), .s_axis_tready(s_ready[g]),
         .s_axis_tlast(1'b0),
         .m_axis_tdata(m_data[g]), .m_axis_tvalid(m_valid[g]), .m_axis_tready(m_ready[g]),
         .m_axis_tlast(m_last[g]), .busy(busy[g])
`ifdef SPI_SLAVE_AXIS_STATUS_EN
         , .overflow(ovf[g]), .underrun(udr[g]), .frame_count(fc[g])
`endif
      );
   end

   always @(posedge clk_in)
      if (mon_en && m_valid[0] && m_ready[0]) got.push_back({m_last[0], m_data[0]});

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic xfer(input int d, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         int k;
         k = MSB_V[d] ? 7 - i : i;
         if (!CPHA_V[d]) mosi = tx[k];
         cycles(H);
         sclk[d] = ~CPOL_V[d];
         if (CPHA_V[d]) mosi = tx[k];
         else rx[k] = miso[d];
         cycles(H);
         sclk[d] = CPOL_V[d];
         if (CPHA_V[d]) rx[k] = miso[d];
      end
   endtask

   task automatic cs_low(input int d);
      cs[d] = 1'b0;
      cycles(H);
   endtask

   task automatic cs_high(input int d);
      cycles(H);
      cs[d] = 1'b1;
      cycles(H);
   endtask

   task automatic drain(input int d, input string name);
      m_ready[d] = 1'b1;
      cycles(1);
      m_ready[d] = 1'b0;
      check(name, m_valid[d], 1'b0);
   endtask

   initial begin
      tbl[0] = '{0, 1'b1, 8'h5A, 8'h81, 8'h5A, 8'h81};
      tbl[1] = '{1, 1'b1, 8'hC3, 8'h81, 8'hC3, 8'h81};
      tbl[2] = '{2, 1'b0, 8'h00, 8'h81, 8'hFF, 8'h81};
      tbl[3] = '{3, 1'b1, 8'h96, 8'h81, 8'h96, 8'h81};
      tbl[4] = '{4, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
      tbl[5] = '{4, 1'b0, 8'h00, 8'hB4, 8'hFF, 8'hB4};
      tbl[6] = '{2, 1'b1, 8'h3E, 8'h7C, 8'h3E, 8'h7C};

      cycles(3);
      for (int d = 0; d < N; d++) begin
         check($sformatf("rst%0d m_valid", d), m_valid[d], 1'b0);
         check($sformatf("rst%0d busy", d), busy[d], 1'b0);
         check($sformatf("rst%0d miso_oe", d), miso_oe[d], 1'b0);
         check($sformatf("rst%0d miso", d), miso[d], 1'b0);
         check($sformatf("rst%0d s_ready", d), s_ready[d], 1'b0);
      end
      rst_in = 1'b1;
      cycles(5);

      for (int i = 0; i < 7; i++) begin
         vec_t v;
         v = tbl[i];
         s_data[v.d]  = v.stx;
         s_valid[v.d] = v.tv;
         cs_low(v.d);
         s_valid[v.d] = 1'b0;
         xfer(v.d, v.mtx, 8, r0);
         cs_high(v.d);
         check($sformatf("vec%0d m_valid", i), m_valid[v.d], 1'b1);
         check($sformatf("vec%0d m_data", i), m_data[v.d], v.data);
         check($sformatf("vec%0d m_last", i), m_last[v.d], 1'b1);
         check($sformatf("vec%0d miso byte", i), r0, v.mrx);
         drain(v.d, $sformatf("vec%0d drain", i));
      end

      s_data[0]  = 8'hA5;
      s_valid[0] = 1'b1;
      m_ready[0] = 1'b1;
      mon_en     = 1'b1;
      cs_low(0);
      s_valid[0] = 1'b0;
      xfer(0, 8'h37, 8, r0);
      xfer(0, 8'h48, 8, r1);
      xfer(0, 8'h59, 8, r2);
      cs_high(0);
      mon_en     = 1'b0;
      m_ready[0] = 1'b0;
      check("3byte miso0", r0, 8'hA5);
      check("3byte miso1", r1, 8'hFF);
      check("3byte miso2", r2, 8'hFF);
      check("3byte count", 16'(got.size()), 16'd3);
      check("3byte out0", got.size() > 0 ? got[0] : 9'h1FF, 9'h037);
      check("3byte out1", got.size() > 1 ? got[1] : 9'h1FF, 9'h048);
      check("3byte out2", got.size() > 2 ? got[2] : 9'h1FF, 9'h159);
`ifdef SPI_SLAVE_AXIS_STATUS_EN
      check("3byte underrun", udr[0], 1'b1);
      check("3byte overflow", ovf[0], 1'b0);
`endif

      cs_low(0);
      xfer(0, 8'h11, 8, r0);
      xfer(0, 8'h22, 8, r0);
      check("stall first valid", m_valid[0], 1'b1);
      check("stall first data", m_data[0], 8'h11);
      xfer(0, 8'h33, 8, r0);
      check("stall mid data", m_data[0], 8'h11);
      cs_high(0);
      check("stall end valid", m_valid[0], 1'b1);
      check("stall end data", m_data[0], 8'h11);
      check("stall end last", m_last[0], 1'b0);
`ifdef SPI_SLAVE_AXIS_STATUS_EN
      check("stall overflow", ovf[0], 1'b1);
`endif
      drain(0, "stall drain");

      cs_low(0);
      xfer(0, 8'hFF, 5, r0);
      cs_high(0);
      check("partial no output", m_valid[0], 1'b0);
      cs_low(0);
      xfer(0, 8'h3C, 8, r0);
      cs_high(0);
      check("after partial valid", m_valid[0], 1'b1);
      check("after partial data", m_data[0], 8'h3C);
      check("after partial last", m_last[0], 1'b1);

      cs_low(0);
      xfer(0, 8'hAA, 4, r0);
      rst_in = 1'b0;
      cycles(2);
      check("midrst m_valid", m_valid[0], 1'b0);
      check("midrst m_data", m_data[0], 8'h00);
      check("midrst m_last", m_last[0], 1'b0);
      check("midrst s_ready", s_ready[0], 1'b0);
      check("midrst miso", miso[0], 1'b0);
      check("midrst miso_oe", miso_oe[0], 1'b0);
      check("midrst busy", busy[0], 1'b0);
`ifdef SPI_SLAVE_AXIS_STATUS_EN
      check("midrst overflow", ovf[0], 1'b0);
      check("midrst underrun", udr[0], 1'b0);
      check("midrst frame_count", fc[0], 16'd0);
`endif
      rst_in = 1'b1;
      cycles(4);
      check("waitcs busy", busy[0], 1'b1);
      xfer(0, 8'hAA, 8, r0);
      xfer(0, 8'h55, 8, r0);
      check("waitcs no output", m_valid[0], 1'b0);
      cs_high(0);
      check("waitcs end no output", m_valid[0], 1'b0);
      cs_low(0);
      xfer(0, 8'h7E, 8, r0);
      cs_high(0);
      check("postrst valid", m_valid[0], 1'b1);
      check("postrst data", m_data[0], 8'h7E);
      check("postrst last", m_last[0], 1'b1);
`ifdef SPI_SLAVE_AXIS_STATUS_EN
      check("postrst frame_count", fc[0], 16'd1);
      check("postrst overflow", ovf[0], 1'b0);
      check("postrst underrun", udr[0], 1'b1);
`endif
      drain(0, "postrst drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
